// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pc_seq_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Sequential fetch step in bytes
    localparam int PC_INC = 4;

    // Low address bits that must be zero for a legal 4-byte target
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Source selected by the next-PC mux
    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_INC   = 3'd1,
        SEL_TRAP  = 3'd2,
        SEL_TRET  = 3'd3,
        SEL_REDIR = 3'd4
    } pc_sel_e;

    function automatic logic misaligned(input logic [1:0] lsb);
        return |(lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between next-PC logic and the PC sequencer.
// Latency: n/a (wires only).
// Backpressure: stall is the only hold mechanism; no valid/ready handshake.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            trap;
    logic [XLEN-1:0] trap_vec;
    logic            trap_ret;
    logic            halt_req;
    logic            resume;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            pc_valid;
    logic [XLEN-1:0] epc;
    logic            misalign;
    logic [XLEN-1:0] badaddr;
    logic            halted;

    // Core side: issues requests, consumes fetch address
    modport master (
        output stall, redirect, redirect_target, trap, trap_vec, trap_ret,
               halt_req, resume,
        input  pc, pc_plus4, pc_valid, epc, misalign, badaddr, halted
    );

    // Sequencer side
    modport slave (
        input  stall, redirect, redirect_target, trap, trap_vec, trap_ret,
               halt_req, resume,
        output pc, pc_plus4, pc_valid, epc, misalign, badaddr, halted
    );
endinterface

// File: rtl/pc_seq_fsm.sv
// BOOT/RUN/HALT control state machine for the PC sequencer.
// Latency: state and flags change one cycle after the request edge.
// Backpressure: none; halt_req beats resume while running.
module pc_seq_fsm
    import pc_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic halt_req,
    input  logic resume,
    output logic pc_valid,
    output logic halted
);
    localparam logic [1:0] S_BOOT = ST_BOOT;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_HALT = ST_HALT;

    logic [1:0] state;
    logic [1:0] state_nxt;

    // Next-state selection; BOOT always lasts exactly one cycle
    always_comb begin
        state_nxt = S_BOOT;
        case (state)
            S_BOOT:  state_nxt = S_RUN;
            S_RUN:   state_nxt = halt_req ? S_HALT : S_RUN;
            S_HALT:  state_nxt = resume ? S_RUN : S_HALT;
            default: state_nxt = S_BOOT;
        endcase
    end

    // State register with registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_BOOT;
            pc_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_valid <= (state_nxt == S_RUN);
            halted   <= (state_nxt == S_HALT);
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Parametrised program counter with redirect, trap/return, halt and alignment check.
// Latency: every request lands on pc at the next rising edge; pc_plus4 is combinational.
// Backpressure: stall holds pc; trap/trap_ret/redirect override stall. Option: PC_SEQ_RETIRE_CNT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              CNT_W        = 32
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
`ifdef PC_SEQ_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);
    if (!(XLEN == 32 || XLEN == 64) || CNT_W < 1 || RESET_VECTOR[1:0] != 2'b00) begin : g_bad_cfg
        $error("pc_sequencer: unsupported parameter combination");
    end

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] badaddr_q;
    logic            misalign_q;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] tgt;
    pc_sel_e         sel;
    logic            run;
    logic            reject;

    pc_seq_fsm u_fsm (
        .clk      (clk),
        .rst      (rst),
        .halt_req (bus.halt_req),
        .resume   (bus.resume),
        .pc_valid (bus.pc_valid),
        .halted   (bus.halted)
    );

    assign run    = bus.pc_valid;
    assign pc_inc = pc_q + XLEN'(PC_INC);

    // Priority pick of the next-PC source; only RUN may move the pc
    always_comb begin
        sel = SEL_HOLD;
        tgt = pc_q;
        if (run) begin
            if (bus.trap) begin
                sel = SEL_TRAP;
                tgt = bus.trap_vec;
            end else if (bus.trap_ret) begin
                sel = SEL_TRET;
                tgt = epc_q;
            end else if (bus.redirect) begin
                sel = SEL_REDIR;
                tgt = bus.redirect_target;
            end else if (!bus.stall) begin
                sel = SEL_INC;
                tgt = pc_inc;
            end
        end
    end

    // Sequential increment is always aligned, so only jump-style targets are checked
    assign reject = (sel == SEL_TRAP || sel == SEL_TRET || sel == SEL_REDIR) &&
                    misaligned(tgt[1:0]);

    // PC / EPC / bad-address datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            badaddr_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= reject;
            if (reject) begin
                badaddr_q <= tgt;
            end else begin
                if (sel != SEL_HOLD) pc_q <= tgt;
                if (sel == SEL_TRAP) epc_q <= pc_q;
            end
        end
    end

`ifdef PC_SEQ_RETIRE_CNT_EN
    // Count RUN cycles that fetch without stall or rejection
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (run && !bus.stall && !reject) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end
`endif

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_inc;
    assign bus.epc      = epc_q;
    assign bus.badaddr  = badaddr_q;
    assign bus.misalign = misalign_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then randomized requests.
// Latency: expectations are pushed at the driving edge and popped one edge later.
// Backpressure: exercises stall, halt and every override combination.
module tb_pc_sequencer;
    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0100;
    localparam logic [63:0] MOD  = 64'h1_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(XLEN)) bus ();
`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    pc_sequencer #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .CNT_W        (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PC_SEQ_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] epc;
        logic [31:0] badaddr;
        logic [31:0] cnt;
        logic        pc_valid;
        logic        halted;
        logic        misalign;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: abstract mode plus byte-address arithmetic
    typedef enum {M_BOOT, M_RUN, M_HALT} mode_t;
    mode_t       m_mode = M_BOOT;
    logic [63:0] m_pc   = 64'(RV);
    logic [63:0] m_epc  = 0;
    logic [63:0] m_bad  = 0;
    logic [63:0] m_cnt  = 0;
    logic        m_mis  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit bad_align(input logic [63:0] a);
        return (a % 4) != 0;
    endfunction

    task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] rt,
                        input logic tp, input logic [31:0] tv, input logic tr,
                        input logic hr, input logic rs);
        exp_t e;
        bit   rej;
        @(negedge clk);
        rst                 = r;
        bus.stall           = st;
        bus.redirect        = rd;
        bus.redirect_target = rt;
        bus.trap            = tp;
        bus.trap_vec        = tv;
        bus.trap_ret        = tr;
        bus.halt_req        = hr;
        bus.resume          = rs;
        rej = 1'b0;
        if (r) begin
            m_mode = M_BOOT; m_pc = 64'(RV); m_epc = 0; m_bad = 0; m_cnt = 0;
        end else if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
        end else if (m_mode == M_HALT) begin
            if (rs) m_mode = M_RUN;
        end else begin
            if (tp) begin
                if (bad_align(64'(tv))) begin rej = 1'b1; m_bad = 64'(tv); end
                else begin m_epc = m_pc; m_pc = 64'(tv); end
            end else if (tr) begin
                if (bad_align(m_epc)) begin rej = 1'b1; m_bad = m_epc; end
                else m_pc = m_epc;
            end else if (rd) begin
                if (bad_align(64'(rt))) begin rej = 1'b1; m_bad = 64'(rt); end
                else m_pc = 64'(rt);
            end else if (!st) begin
                m_pc = (m_pc + 4) % MOD;
            end
            if (!st && !rej) m_cnt = (m_cnt + 1) % MOD;
            if (hr) m_mode = M_HALT;
        end
        m_mis      = rej;
        e.pc       = m_pc[31:0];
        e.pc_plus4 = 32'((m_pc + 4) % MOD);
        e.epc      = m_epc[31:0];
        e.badaddr  = m_bad[31:0];
        e.cnt      = m_cnt[31:0];
        e.pc_valid = (m_mode == M_RUN);
        e.halted   = (m_mode == M_HALT);
        e.misalign = m_mis;
        sbq.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redir(input logic [31:0] t);
        step(0, 0, 1, t, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every registered output against the oldest expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("pc",       64'(bus.pc),       64'(e.pc));
                chk("pc_plus4", 64'(bus.pc_plus4), 64'(e.pc_plus4));
                chk("pc_valid", 64'(bus.pc_valid), 64'(e.pc_valid));
                chk("halted",   64'(bus.halted),   64'(e.halted));
                chk("epc",      64'(bus.epc),      64'(e.epc));
                chk("misalign", 64'(bus.misalign), 64'(e.misalign));
                chk("badaddr",  64'(bus.badaddr),  64'(e.badaddr));
`ifdef PC_SEQ_RETIRE_CNT_EN
                chk("retire_cnt", 64'(retire_cnt), 64'(e.cnt));
`endif
            end
        end
    end

    initial begin : driver
        logic [31:0] t1, t2;
        bus.stall = 0; bus.redirect = 0; bus.redirect_target = 0; bus.trap = 0;
        bus.trap_vec = 0; bus.trap_ret = 0; bus.halt_req = 0; bus.resume = 0;

        // Reset, BOOT, then free-running increments
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); idle(); idle();
        // Redirect beats stall; misaligned redirect is rejected
        redir(32'h200);
        step(0, 1, 1, 32'h400, 0, 0, 0, 0, 0);
        idle();
        redir(32'h402);
        idle();
        // Trap beats redirect, then return; misaligned trap vector keeps epc
        redir(32'h300);
        step(0, 0, 1, 32'h500, 1, 32'h800, 0, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h801, 0, 0, 0);
        // Halt: update still happens, requests ignored, resume continues
        redir(32'h10);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 1, 1, 32'h40, 1, 32'h80, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        // Wrap at 2^32
        redir(32'hFFFF_FFFC);
        idle(); idle();
        // Reset while halted
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // Five RUN cycles with one stall and one rejection, then halt freeze
        idle();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        redir(32'h123);
        idle(); idle();
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(); idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();

        // Randomized requests
        for (int i = 0; i < 600; i++) begin
            t1 = $urandom;
            t2 = $urandom;
            if ($urandom_range(0, 3) != 0) t1[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) t2[1:0] = 2'b00;
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0, t1,
                 $urandom_range(0, 11) == 0, t2,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0);
        end

        @(posedge clk);
        #2;
        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
